// File: rtl/nib_chk_pkg.sv
// nib_chk_pkg: shared state type and defaults for the nibble sequence checker
package nib_chk_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HUNT = 2'd1, LOCKED = 2'd2} state_t;
  localparam logic [3:0] IDLE_VAL_DEF = 4'hA;
  localparam int SYNC_LEN_DEF = 3;
  localparam int MISS_LIMIT = 2;
endpackage

// File: rtl/nib_seq_chk_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clr) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/nib_seq_chk.sv
// nib_seq_chk: incrementing-nibble stream checker; NIB_SEQ_CHK_STICKY_EN adds err_clr/err_sticky
module nib_seq_chk
  import nib_chk_pkg::*;
#(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] IDLE_VAL = WIDTH'(IDLE_VAL_DEF),
  parameter int              SYNC_LEN  = SYNC_LEN_DEF,
  parameter int              ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     d_in,
  input  logic                 chk_en,
  output logic                 sync_ok,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0]     exp_val,
  input  logic                 test_mode,
  input  logic                 scan_en,
  input  logic                 scan_in0,
  output logic                 scan_out0
`ifdef NIB_SEQ_CHK_STICKY_EN
  ,
  input  logic                 err_clr,
  output logic                 err_sticky
`endif
);
  localparam int MW = $clog2(MISS_LIMIT + 1);
  state_t        state;
  logic [3:0]    run_cnt;
  logic [MW-1:0] miss_cnt;
  logic          match, miss, last_miss, unused_dft;
  assign match      = d_in == exp_val;
  assign miss       = chk_en && state == LOCKED && !match;
  assign last_miss  = miss_cnt == MW'(MISS_LIMIT - 1);
  assign scan_out0  = 1'b0;
  assign unused_dft = ^{test_mode, scan_en, scan_in0};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      exp_val   <= '0;
      run_cnt   <= '0;
      miss_cnt  <= '0;
      sync_ok   <= 1'b0;
      err_pulse <= 1'b0;
    end else if (!chk_en) begin
      state     <= IDLE;
      run_cnt   <= '0;
      miss_cnt  <= '0;
      sync_ok   <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= miss;
      case (state)
        IDLE:
          if (d_in != IDLE_VAL) begin
            exp_val <= d_in + 1'b1;
            run_cnt <= 4'd1;
            state   <= HUNT;
          end
        HUNT:
          if (match) begin
            exp_val <= exp_val + 1'b1;
            run_cnt <= run_cnt + 4'd1;
            if (run_cnt + 4'd1 == 4'(SYNC_LEN)) begin
              state   <= LOCKED;
              sync_ok <= 1'b1;
            end
          end else begin
            exp_val <= d_in + 1'b1;
            run_cnt <= 4'd1;
          end
        LOCKED:
          if (match) begin
            exp_val  <= exp_val + 1'b1;
            miss_cnt <= '0;
          end else if (last_miss) begin
            state    <= HUNT;
            exp_val  <= d_in + 1'b1;
            run_cnt  <= 4'd1;
            miss_cnt <= '0;
            sync_ok  <= 1'b0;
          end else begin
            exp_val  <= exp_val + 1'b1;
            miss_cnt <= miss_cnt + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (miss),
    .clr  (1'b0),
    .count(err_cnt)
  );
`ifdef NIB_SEQ_CHK_STICKY_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) err_sticky <= 1'b0;
    else err_sticky <= miss | (err_sticky & ~err_clr);
`endif
endmodule

// File: tb/tb_nib_seq_chk.sv
// tb_nib_seq_chk: directed and randomized checks of nib_seq_chk against a queue-based stream model
module tb_nib_seq_chk;
  import nib_chk_pkg::*;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] d_in = 4'hA;
  logic       chk_en = 1'b1;
  logic       err_clr = 1'b0;
  logic       sync_ok, err_pulse, scan_out0, s_sync_ok, s_err_pulse, s_scan_out0;
  logic [7:0] err_cnt;
  logic [1:0] s_err_cnt;
  logic [3:0] exp_val, s_exp_val;
  logic       err_sticky, s_err_sticky;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  nib_seq_chk dut (
    .clk(clk), .reset(reset), .d_in(d_in), .chk_en(chk_en),
    .sync_ok(sync_ok), .err_pulse(err_pulse), .err_cnt(err_cnt), .exp_val(exp_val),
    .test_mode(1'b0), .scan_en(1'b0), .scan_in0(1'b0), .scan_out0(scan_out0)
`ifdef NIB_SEQ_CHK_STICKY_EN
    , .err_clr(err_clr), .err_sticky(err_sticky)
`endif
  );

  nib_seq_chk #(.ERR_CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .d_in(d_in), .chk_en(chk_en),
    .sync_ok(s_sync_ok), .err_pulse(s_err_pulse), .err_cnt(s_err_cnt), .exp_val(s_exp_val),
    .test_mode(1'b0), .scan_en(1'b0), .scan_in0(1'b0), .scan_out0(s_scan_out0)
`ifdef NIB_SEQ_CHK_STICKY_EN
    , .err_clr(err_clr), .err_sticky(s_err_sticky)
`endif
  );

  // Reference model: the hunt run is the list of samples seen since the last restart.
  bit         m_idle = 1, m_lock = 0, m_prev_miss = 0, m_pulse = 0, m_sticky = 0;
  logic [3:0] m_exp = 4'h0;
  logic [3:0] hist[$];
  int         m_errs = 0;

  task automatic model_reset();
    m_idle = 1; m_lock = 0; m_prev_miss = 0; m_pulse = 0; m_sticky = 0;
    m_exp = 4'h0; m_errs = 0; hist.delete();
  endtask

  task automatic model_clk(input logic [3:0] d, input logic en, input logic clr);
    m_pulse = 0;
    if (!en) begin
      m_idle = 1; m_lock = 0; m_prev_miss = 0; hist.delete();
    end else if (m_idle) begin
      if (d != 4'hA) begin m_idle = 0; hist = '{d}; m_exp = d + 4'd1; end
    end else if (!m_lock) begin
      if (d == m_exp) hist.push_back(d);
      else hist = '{d};
      m_exp = d + 4'd1;
      if (hist.size() == SYNC_LEN_DEF) m_lock = 1;
    end else if (d == m_exp) begin
      m_exp = m_exp + 4'd1; m_prev_miss = 0;
    end else begin
      m_pulse = 1; m_errs++;
      if (m_prev_miss) begin m_lock = 0; hist = '{d}; m_exp = d + 4'd1; m_prev_miss = 0; end
      else begin m_prev_miss = 1; m_exp = m_exp + 4'd1; end
    end
    m_sticky = m_pulse | (m_sticky & !clr);
  endtask

  task automatic step(input logic [3:0] v);
    d_in = v;
    @(posedge clk);
    model_clk(v, chk_en, err_clr);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; d_in = 4'hA; chk_en = 1;
    #1;
    total++; if ({sync_ok, err_pulse, err_cnt, exp_val, scan_out0} !== 15'd0) begin bad++; $display("FAIL reset_outs got=%h want=0", {sync_ok, err_pulse, err_cnt, exp_val, scan_out0}); end
    total++; if (s_err_cnt !== 2'd0) begin bad++; $display("FAIL reset_s_cnt got=%0d want=0", s_err_cnt); end
    @(negedge clk) reset = 0;
    model_reset();
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 8; i++) begin
      step(4'hA);
      total++; if ({sync_ok, err_pulse, err_cnt} !== 10'd0) begin bad++; $display("FAIL idle_hold cyc=%0d got=%h want=0", i, {sync_ok, err_pulse, err_cnt}); end
    end
  endtask

  task automatic test_lock();
    step(4'h3); step(4'h4);
    total++; if (sync_ok !== 1'b0) begin bad++; $display("FAIL lock_early got=%b want=0", sync_ok); end
    step(4'h5);
    total++; if (sync_ok !== 1'b1) begin bad++; $display("FAIL lock_sync got=%b want=1", sync_ok); end
    total++; if (exp_val !== 4'h6) begin bad++; $display("FAIL lock_exp got=%h want=6", exp_val); end
  endtask

  task automatic test_wrap();
    for (int v = 6; v <= 13; v++) step(4'(v));
    for (int v = 14; v <= 17; v++) begin
      step(4'(v));
      total++; if ({sync_ok, err_pulse} !== 2'b10) begin bad++; $display("FAIL wrap v=%h got sync/pulse=%b want=10", 4'(v), {sync_ok, err_pulse}); end
    end
    total++; if (exp_val !== 4'h2) begin bad++; $display("FAIL wrap_exp got=%h want=2", exp_val); end
  endtask

  task automatic test_single_miss();
    for (int v = 2; v <= 6; v++) step(4'(v));
    step(4'h9);
    total++; if ({err_pulse, err_cnt} !== 9'h101) begin bad++; $display("FAIL single_pulse got=%h want=101", {err_pulse, err_cnt}); end
    step(4'h8);
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL single_one_cycle got=%b want=0", err_pulse); end
    step(4'h9);
    total++; if ({sync_ok, exp_val, err_cnt} !== 13'h1A01) begin bad++; $display("FAIL single_end got=%h want=1a01", {sync_ok, exp_val, err_cnt}); end
  endtask

  task automatic test_double_miss();
    for (int v = 10; v <= 22; v++) step(4'(v));
    step(4'h9);
    total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL double_first got=%b want=1", err_pulse); end
    step(4'h2);
    total++; if ({err_pulse, sync_ok, exp_val, err_cnt} !== 14'h2303) begin bad++; $display("FAIL double_second got=%h want=2303", {err_pulse, sync_ok, exp_val, err_cnt}); end
    step(4'h3);
    total++; if ({err_pulse, sync_ok} !== 2'b00) begin bad++; $display("FAIL resync_hunt got=%b want=00", {err_pulse, sync_ok}); end
    step(4'h4);
    total++; if ({sync_ok, exp_val} !== 5'h15) begin bad++; $display("FAIL resync_lock got=%h want=15", {sync_ok, exp_val}); end
  endtask

  task automatic test_saturation();
    logic [3:0] e;
    e = 4'h5;
    for (int i = 0; i < 5; i++) begin
      step(e + 4'd8);
      step(e + 4'd1);
      e = e + 4'd2;
    end
    total++; if (s_err_cnt !== 2'd3) begin bad++; $display("FAIL sat_narrow got=%0d want=3", s_err_cnt); end
    total++; if ({sync_ok, err_cnt} !== 9'h108) begin bad++; $display("FAIL sat_wide got=%h want=108", {sync_ok, err_cnt}); end
    total++; if (exp_val !== 4'hF) begin bad++; $display("FAIL sat_exp got=%h want=f", exp_val); end
  endtask

  task automatic test_chk_en();
    chk_en = 0;
    step(4'h7);
    total++; if ({sync_ok, exp_val, err_cnt} !== 13'h0F08) begin bad++; $display("FAIL chk_en_off got=%h want=0f08", {sync_ok, exp_val, err_cnt}); end
    chk_en = 1;
    step(4'hA);
    total++; if ({sync_ok, exp_val} !== 5'h0F) begin bad++; $display("FAIL chk_en_idle got=%h want=0f", {sync_ok, exp_val}); end
    step(4'h1);
    total++; if (exp_val !== 4'h2) begin bad++; $display("FAIL chk_en_hunt got=%h want=2", exp_val); end
  endtask

  task automatic test_reset_mid();
    step(4'h2); step(4'h3);
    total++; if (sync_ok !== 1'b1) begin bad++; $display("FAIL mid_locked got=%b want=1", sync_ok); end
    step(4'h0);
    total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL mid_pulse got=%b want=1", err_pulse); end
    #2 reset = 1;
    #1;
    total++; if ({sync_ok, err_pulse, err_cnt, exp_val, s_err_cnt} !== 16'd0) begin bad++; $display("FAIL mid_reset got=%h want=0", {sync_ok, err_pulse, err_cnt, exp_val, s_err_cnt}); end
    @(negedge clk) reset = 0;
    model_reset();
    d_in = 4'hA;
    step(4'hA);
    total++; if ({sync_ok, exp_val} !== 5'd0) begin bad++; $display("FAIL mid_resume got=%h want=0", {sync_ok, exp_val}); end
  endtask

  task automatic test_random();
    logic [3:0] v;
    for (int i = 0; i < 600; i++) begin
      chk_en  = $urandom_range(39, 0) != 0;
      err_clr = $urandom_range(7, 0) == 0;
      v = ($urandom_range(9, 0) < 7) ? m_exp : 4'($urandom_range(15, 0));
      step(v);
      total++; if ({sync_ok, err_pulse, exp_val, scan_out0} !== {m_lock, m_pulse, m_exp, 1'b0}) begin bad++; $display("FAIL rnd_state cyc=%0d got=%h want=%h", i, {sync_ok, err_pulse, exp_val, scan_out0}, {m_lock, m_pulse, m_exp, 1'b0}); end
      total++; if (err_cnt !== 8'(m_errs > 255 ? 255 : m_errs)) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d want=%0d", i, err_cnt, m_errs); end
      total++; if (s_err_cnt !== 2'(m_errs > 3 ? 3 : m_errs)) begin bad++; $display("FAIL rnd_sat cyc=%0d got=%0d want=%0d", i, s_err_cnt, m_errs > 3 ? 3 : m_errs); end
`ifdef NIB_SEQ_CHK_STICKY_EN
      total++; if ({err_sticky, s_err_sticky} !== {2{m_sticky}}) begin bad++; $display("FAIL rnd_sticky cyc=%0d got=%b want=%b", i, {err_sticky, s_err_sticky}, {2{m_sticky}}); end
`endif
    end
    chk_en = 1; err_clr = 0;
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_lock();
    test_wrap();
    test_single_miss();
    test_double_miss();
    test_saturation();
    test_chk_en();
    test_reset_mid();
    test_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
